stage_mem: RTL and testbench
============================

// Module: stage_mem
// PURPOSE
//  Stage 4 of the 5-stage MIPS pipeline: consumes EX results (ALU answer, dest reg, store data), holds the EX/MEM register,
//  runs loads/stores on the data-memory req/ack bus and produces the registered MEM/WB outputs.
//  Stalls upstream while a bus access is outstanding; flags misaligned accesses and bus timeouts.
// PARAMETERS
//  ACK_TIMEOUT  255  max wait cycles after req before an access is abandoned (1..255)
// PORTS
//  clk            in   1   pipeline clock; everything on rising edge
//  rst_n          in   1   asynchronous, active-low reset
//  ex_valid       in   1   EX slot holds a real instruction
//  ex_ans         in   32  ALU result: memory address or pass-through result
//  ex_rw          in   5   destination register
//  ex_wreg        in   1   instruction writes the register file
//  ex_sdata       in   32  store data (rt)
//  ex_memop       in   3   memory op (encoding in package)
//  mem_stall      out  1   upstream must hold ex_* and not advance
//  dm_req         out  1   data-memory request
//  dm_we          out  1   1 = write
//  dm_addr        out  32  word address {M.ans[31:2],2'b00}
//  dm_wdata       out  32  write data, byte-replicated for SB
//  dm_be          out  4   byte enables
//  dm_rdata       in   32  read data, valid with dm_ack
//  dm_ack         in   1   access complete this cycle
//  wb_valid       out  1   one-cycle pulse per retired instruction
//  wb_rw          out  5   destination register
//  wb_wreg        out  1   register write enable (0 for stores, faults)
//  wb_data        out  32  load data or pass-through ALU result
//  wb_exc         out  2   00 ok, 01 misaligned, 10 bus timeout
// BEHAVIOUR
//  - Reset: M register valid=0, FSM=IDLE, wait counter=0; all wb_* = 0; dm_req=0, mem_stall=0 immediately (async).
//  - EX/MEM latch: loads ex_* on edge when mem_stall=0; ex_valid=0 loads a bubble.
//  - Non-memory op (NONE): retires next edge, latency 1; wb_data=M.ans.
//  - Misaligned (LW with ans[1:0]!=0, SW likewise): no dm_req; retires next edge with wb_exc=01, wb_wreg=0.
//  - Aligned mem op, FSM IDLE: dm_req=1 combinationally from M; if dm_ack same cycle -> retire at that edge, latency 1.
//    Else mem_stall=1, FSM->WAIT.
//  - WAIT: dm_req, dm_we, dm_addr, dm_wdata, dm_be held stable; counter increments per cycle.
//    dm_ack -> retire, FSM->IDLE, counter=0, mem_stall drops that cycle.
//    Counter reaches ACK_TIMEOUT without ack -> dm_req drops, retire with wb_exc=10, wb_wreg=0, FSM->IDLE.
//  - mem_stall = M.valid & aligned mem op & ~dm_ack & ~timeout.
//  - Loads (little-endian, byte k = ans[1:0]):
//    LW -> rdata; LB -> sign-ext rdata[8k+7:8k]; LBU -> zero-ext.
//  - Stores: SW be=4'hF wdata=sdata; SB be=1<<k wdata={4{sdata[7:0]}}; wb_wreg=0.
//  - wb_* registered; updated only on retire edge, else wb_valid=0 and remaining wb_* hold last value.
//  - dm_ack with dm_req=0 is ignored. ex_* changing during stall is a protocol violation (bench assertion).
//  - Reset mid-access: req drops at once; the abandoned access is never retired.
// STRUCTURE
//  - Package cpu_defs_pkg: MEMOP_NONE=000, LW=001, LB=010, LBU=011, SW=101, SB=110; EXC_OK/MISALIGN/TIMEOUT;
//    FSM state enum IDLE/WAIT.
//  - Sub-module stage_mem_align (combinational): load byte extract/extend and store replicate/byte-enable generation.
//  - Top: EX/MEM register, FSM + wait counter, MEM/WB register.
// TESTING
//  1. ALU op ans=0x1234, rw=5, wreg=1, NONE -> next edge wb_valid=1 wb_data=0x1234 wb_rw=5, no dm_req.
//  2. LB ans=0x103, mem[0x100]=0x80FF_0000, ack same cycle
//     -> dm_addr=0x100, wb_data=0xFFFF_FF80; LBU gives 0x0000_0080.
//  3. SB ans=0x202, sdata=0xAB -> dm_be=0100, dm_wdata=0xABABABAB, dm_we=1, wb_wreg=0.
//  4. LW with ack after 3 cycles -> mem_stall=1 for 3 cycles, req/addr stable, wb_valid once, then next op flows.
//  5. LW ans=0x101 -> no dm_req, wb_exc=01, wb_wreg=0; ACK_TIMEOUT=4, no ack -> req drops after 4 cycles, wb_exc=10.
//  6. rst_n low during WAIT -> dm_req=0 and mem_stall=0 immediately; no wb_valid after release.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg: memory-op encodings, exception codes, FSM states and the EX/MEM register layout
package cpu_defs_pkg;
  localparam logic [2:0] MEMOP_NONE = 3'b000;
  localparam logic [2:0] MEMOP_LW   = 3'b001;
  localparam logic [2:0] MEMOP_LB   = 3'b010;
  localparam logic [2:0] MEMOP_LBU  = 3'b011;
  localparam logic [2:0] MEMOP_SW   = 3'b101;
  localparam logic [2:0] MEMOP_SB   = 3'b110;
  typedef enum logic [1:0] {EXC_OK = 2'b00, EXC_MISALIGN = 2'b01, EXC_TIMEOUT = 2'b10} exc_e;
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;
  typedef struct packed {
    logic        valid;
    logic [31:0] ans;
    logic [4:0]  rw;
    logic        wreg;
    logic [31:0] sdata;
    logic [2:0]  memop;
  } exmem_t;
  function automatic logic is_mem(input logic [2:0] op);
    return op inside {MEMOP_LW, MEMOP_LB, MEMOP_LBU, MEMOP_SW, MEMOP_SB};
  endfunction
  function automatic logic is_store(input logic [2:0] op);
    return op == MEMOP_SW || op == MEMOP_SB;
  endfunction
  function automatic logic is_word(input logic [2:0] op);
    return op == MEMOP_LW || op == MEMOP_SW;
  endfunction
endpackage

// File: rtl/stage_mem_align.sv
// stage_mem_align: load byte extract/extend, store byte replication and byte-enable generation
module stage_mem_align
  import cpu_defs_pkg::*;
(
  input  logic [2:0]  i_memop,
  input  logic [1:0]  i_k,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_sdata,
  output logic [31:0] o_ldata,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_be
);
  logic [7:0] w_byte;
  always_comb begin
    w_byte  = i_rdata[{i_k, 3'b000} +: 8];
    o_ldata = i_memop == MEMOP_LB ? {{24{w_byte[7]}}, w_byte} : i_memop == MEMOP_LBU ? {24'h0, w_byte} : i_rdata;
    o_wdata = i_memop == MEMOP_SB ? {4{i_sdata[7:0]}} : i_sdata;
    o_be    = i_memop inside {MEMOP_LB, MEMOP_LBU, MEMOP_SB} ? 4'b0001 << i_k : 4'hF;
  end
endmodule

// File: rtl/stage_mem.sv
// stage_mem: MIPS MEM stage with EX/MEM register, req/ack data-memory FSM and registered MEM/WB outputs
module stage_mem
  import cpu_defs_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] ex_ans,
  input  logic [4:0]  ex_rw,
  input  logic        ex_wreg,
  input  logic [31:0] ex_sdata,
  input  logic [2:0]  ex_memop,
  output logic        mem_stall,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_be,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        wb_valid,
  output logic [4:0]  wb_rw,
  output logic        wb_wreg,
  output logic [31:0] wb_data,
  output logic [1:0]  wb_exc
);
  exmem_t      r_m;
  state_e      r_state;
  logic [7:0]  r_cnt;
  logic        w_mis, w_acc, w_timeout, w_ack, w_retire, w_load_ok;
  logic [1:0]  w_exc;
  logic [31:0] w_ldata;
  stage_mem_align u_align (
    .i_memop (r_m.memop),
    .i_k     (r_m.ans[1:0]),
    .i_rdata (dm_rdata),
    .i_sdata (r_m.sdata),
    .o_ldata (w_ldata),
    .o_wdata (dm_wdata),
    .o_be    (dm_be)
  );
  always_comb begin
    w_mis     = r_m.valid & is_word(r_m.memop) & (r_m.ans[1:0] != 2'b00);
    w_acc     = r_m.valid & is_mem(r_m.memop) & ~w_mis;
    w_timeout = r_state == WAIT && r_cnt == 8'(ACK_TIMEOUT);
    dm_req    = w_acc & ~w_timeout;
    dm_we     = is_store(r_m.memop);
    dm_addr   = {r_m.ans[31:2], 2'b00};
    w_ack     = dm_req & dm_ack;
    mem_stall = dm_req & ~dm_ack;
    w_retire  = r_m.valid & ~mem_stall;
    w_exc     = w_mis ? EXC_MISALIGN : (w_acc & ~w_ack) ? EXC_TIMEOUT : EXC_OK;
    w_load_ok = is_mem(r_m.memop) & ~dm_we & (w_exc == EXC_OK);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_m      <= '0;
      r_state  <= IDLE;
      r_cnt    <= '0;
      wb_valid <= 1'b0;
      wb_rw    <= '0;
      wb_wreg  <= 1'b0;
      wb_data  <= '0;
      wb_exc   <= EXC_OK;
    end else begin
      if (!mem_stall) r_m <= '{ex_valid, ex_ans, ex_rw, ex_wreg, ex_sdata, ex_memop};
      r_state  <= mem_stall ? WAIT : IDLE;
      r_cnt    <= mem_stall ? r_cnt + 8'd1 : 8'd0;
      wb_valid <= w_retire;
      if (w_retire) begin
        wb_rw   <= r_m.rw;
        wb_wreg <= r_m.wreg & ~dm_we & (w_exc == EXC_OK);
        wb_data <= w_load_ok ? w_ldata : r_m.ans;
        wb_exc  <= w_exc;
      end
    end
endmodule

// File: tb/tb_stage_mem.sv
// tb_stage_mem: randomized scoreboard bench for stage_mem against a reference memory model
module tb_stage_mem;
  import cpu_defs_pkg::*;
  localparam int TO = 4;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid, ex_wreg, mem_stall, dm_req, dm_we, dm_ack, wb_valid, wb_wreg;
  logic [31:0] ex_ans, ex_sdata, dm_addr, dm_wdata, dm_rdata, wb_data;
  logic [4:0]  ex_rw, wb_rw;
  logic [2:0]  ex_memop;
  logic [3:0]  dm_be;
  logic [1:0]  wb_exc;
  stage_mem #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ans(ex_ans), .ex_rw(ex_rw), .ex_wreg(ex_wreg),
    .ex_sdata(ex_sdata), .ex_memop(ex_memop), .mem_stall(mem_stall), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .wb_valid(wb_valid), .wb_rw(wb_rw), .wb_wreg(wb_wreg), .wb_data(wb_data), .wb_exc(wb_exc)
  );
  always #5 clk = ~clk;
  typedef struct {logic [4:0] rw; logic wreg; logic [31:0] data; logic chk; logic [1:0] exc;} exp_t;
  typedef struct {logic [31:0] addr; logic we; logic [31:0] wdata; logic [3:0] be;} req_t;
  exp_t        exp_q[$];
  req_t        req_q[$];
  int          dly_q[$];
  logic [31:0] smem [256];
  logic [31:0] rmem [256];
  int          errors = 0;
  int          checks = 0;
  int          prev_stall = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  assert property (@(posedge clk) disable iff (!rst_n) $past(mem_stall) |-> $stable({ex_valid, ex_ans, ex_rw, ex_wreg, ex_sdata, ex_memop}))
    else begin errors++; $display("FAIL ex_hold: ex_* changed while mem_stall was high"); end
  logic busy = 1'b0;
  int   c, d;
  req_t cur;
  always begin
    @(posedge clk);
    #2;
    dm_ack = 1'b0;
    if (!rst_n || !dm_req) busy = 1'b0;
    else begin
      if (!busy) begin
        busy = 1'b1;
        c = 0;
        if (req_q.size() == 0 || dly_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: dm_req=1 addr=%h with no access outstanding", dm_addr);
          cur = '{dm_addr, dm_we, dm_wdata, dm_be};
          d = 1000;
        end else begin
          cur = req_q.pop_front();
          d = dly_q.pop_front();
          chk("req_addr", 64'(dm_addr), 64'(cur.addr));
          chk("req_we", 64'(dm_we), 64'(cur.we));
          if (cur.we) begin
            chk("req_wdata", 64'(dm_wdata), 64'(cur.wdata));
            chk("req_be", 64'(dm_be), 64'(cur.be));
          end
        end
      end else begin
        chk("hold_addr", 64'(dm_addr), 64'(cur.addr));
        chk("hold_we", 64'(dm_we), 64'(cur.we));
        if (cur.we) chk("hold_wdata_be", {dm_be, dm_wdata}, {cur.be, cur.wdata});
      end
      if (c == d) begin
        dm_ack = 1'b1;
        dm_rdata = smem[dm_addr[9:2]];
        if (dm_we) for (int i = 0; i < 4; i++) if (dm_be[i]) smem[dm_addr[9:2]][8*i +: 8] = dm_wdata[8*i +: 8];
        busy = 1'b0;
      end
      c++;
    end
  end
  exp_t        e;
  logic [7:0]  hold = '0;
  always @(negedge clk) begin
    if (!rst_n) hold = '0;
    else if (wb_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_wb: wb_valid=1 rw=%0d with nothing outstanding", wb_rw);
      end else begin
        e = exp_q.pop_front();
        chk("wb_rw", 64'(wb_rw), 64'(e.rw));
        chk("wb_wreg", 64'(wb_wreg), 64'(e.wreg));
        chk("wb_exc", 64'(wb_exc), 64'(e.exc));
        if (e.chk) chk("wb_data", 64'(wb_data), 64'(e.data));
        hold = {e.rw, e.wreg, e.exc};
      end
    end else chk("wb_hold", 64'({wb_rw, wb_wreg, wb_exc}), 64'(hold));
  end
  task automatic issue(input logic v, input logic [2:0] op, input logic [31:0] ans, input logic [4:0] rw,
                       input logic wr, input logic [31:0] sd, input int dl);
    exp_t        x;
    req_t        r;
    logic        mis, acc, st;
    int          n, k, idx, nxt_stall;
    logic [31:0] w;
    ex_valid = v; ex_memop = op; ex_ans = ans; ex_rw = rw; ex_wreg = wr; ex_sdata = sd;
    nxt_stall = 0;
    if (v) begin
      mis = (op == MEMOP_LW || op == MEMOP_SW) && ans[1:0] != 2'b00;
      acc = op inside {MEMOP_LW, MEMOP_LB, MEMOP_LBU, MEMOP_SW, MEMOP_SB} && !mis;
      st = op == MEMOP_SW || op == MEMOP_SB;
      k = int'(ans[1:0]);
      idx = int'(ans[9:2]);
      x.rw = rw;
      x.exc = mis ? 2'b01 : (acc && dl >= TO) ? 2'b10 : 2'b00;
      x.wreg = wr && x.exc == 2'b00 && !st;
      x.chk = x.exc == 2'b00 && !st;
      x.data = ans;
      if (acc) begin
        r.addr = {ans[31:2], 2'b00};
        r.we = st;
        r.wdata = op == MEMOP_SB ? {4{sd[7:0]}} : sd;
        r.be = op == MEMOP_SB ? 4'(1 << k) : 4'hF;
        req_q.push_back(r);
        dly_q.push_back(dl);
        nxt_stall = dl >= TO ? TO : dl;
        if (x.exc == 2'b00) begin
          w = rmem[idx];
          if (op == MEMOP_LW) x.data = w;
          if (op == MEMOP_LB) x.data = {{24{w[8*k+7]}}, w[8*k +: 8]};
          if (op == MEMOP_LBU) x.data = {24'h0, w[8*k +: 8]};
          if (op == MEMOP_SW) rmem[idx] = sd;
          if (op == MEMOP_SB) rmem[idx][8*k +: 8] = sd[7:0];
        end
      end
      exp_q.push_back(x);
    end
    n = 0;
    @(negedge clk);
    while (mem_stall && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("stall_cycles", 64'(n), 64'(prev_stall));
    prev_stall = nxt_stall;
    @(posedge clk);
    #1;
  endtask
  logic [2:0] ops [6] = '{MEMOP_NONE, MEMOP_LW, MEMOP_LB, MEMOP_LBU, MEMOP_SW, MEMOP_SB};
  initial begin
    logic [2:0]  op;
    logic [31:0] a, v;
    int          dl;
    ex_valid = 0; ex_memop = 0; ex_ans = 0; ex_rw = 0; ex_wreg = 0; ex_sdata = 0; dm_ack = 0; dm_rdata = 0;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      smem[i] = v;
      rmem[i] = v;
    end
    smem[8'h40] = 32'h80FF_0000;
    rmem[8'h40] = 32'h80FF_0000;
    #12;
    chk("rst_dm_req", 64'(dm_req), 0);
    chk("rst_mem_stall", 64'(mem_stall), 0);
    chk("rst_wb", 64'({wb_valid, wb_rw, wb_wreg, wb_data, wb_exc}), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(1, MEMOP_NONE, 32'h1234, 5, 1, 0, 0);
    issue(1, MEMOP_LB, 32'h103, 7, 1, 0, 0);
    issue(1, MEMOP_LBU, 32'h103, 8, 1, 0, 0);
    issue(1, MEMOP_SB, 32'h202, 9, 1, 32'hAB, 0);
    issue(1, MEMOP_LW, 32'h200, 10, 1, 0, 3);
    issue(1, MEMOP_NONE, 32'h55, 11, 1, 0, 0);
    issue(1, MEMOP_LW, 32'h101, 12, 1, 0, 0);
    issue(1, MEMOP_LW, 32'h204, 13, 1, 0, 7);
    issue(1, MEMOP_SW, 32'h208, 14, 1, 32'hDEAD_BEEF, TO);
    issue(1, MEMOP_LW, 32'h208, 15, 1, 0, 1);
    for (int i = 0; i < 400; i++) begin
      op = ops[$urandom_range(0, 5)];
      a = op == MEMOP_NONE ? $urandom : 32'($urandom_range(0, 1023));
      if ((op == MEMOP_LW || op == MEMOP_SW) && $urandom_range(0, 4) != 0) a[1:0] = 2'b00;
      dl = $urandom_range(0, 7) == 0 ? TO + $urandom_range(0, 2) : $urandom_range(0, TO - 1);
      issue(1'($urandom_range(0, 4) != 0), op, a, 5'($urandom), 1'($urandom), $urandom, dl);
    end
    for (int i = 0; i < 3; i++) issue(0, MEMOP_NONE, 0, 0, 0, 0, 0);
    chk("drain_exp_q", 64'(exp_q.size()), 0);
    chk("drain_req_q", 64'(req_q.size()), 0);
    ex_valid = 1; ex_memop = MEMOP_LW; ex_ans = 32'h40; ex_rw = 3; ex_wreg = 1;
    req_q.push_back('{32'h40, 1'b0, 32'h0, 4'hF});
    dly_q.push_back(100);
    @(posedge clk);
    #1 ex_valid = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("wait_stall", 64'({dm_req, mem_stall}), 64'(2'b11));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_dm_req", 64'(dm_req), 0);
    chk("midrst_mem_stall", 64'(mem_stall), 0);
    chk("midrst_wb", 64'({wb_valid, wb_rw, wb_wreg, wb_data, wb_exc}), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    prev_stall = 0;
    for (int i = 0; i < 3; i++) issue(0, MEMOP_NONE, 0, 0, 0, 0, 0);
    issue(1, MEMOP_NONE, 32'hCAFE, 21, 1, 0, 0);
    for (int i = 0; i < 3; i++) issue(0, MEMOP_NONE, 0, 0, 0, 0, 0);
    chk("final_exp_q", 64'(exp_q.size()), 0);
    chk("final_req_q", 64'(req_q.size() + dly_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
